// File: rtl/nbit_demux_collect_pkg.sv
// Shared types and helpers for the bit collector: FSM state encoding and word-width helper.
package nbit_demux_collect_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int word_width(input int select_width);
    return 1 << select_width;
  endfunction

endpackage

// File: rtl/nbit_demux_collect_if.sv
// Bit-write and word-read bus of the collector; the master side is the producer/consumer.
// Handshake: a write is taken on a rising edge where DemuxWrEn=1 and DemuxInReady=1; a word is
// taken on a rising edge where DemuxOutValid=1 and DemuxOutReady=1. DemuxOut is held while valid.
interface nbit_demux_collect_if #(
  parameter int SELECT_WIDTH = 1
);
  localparam int W = 1 << SELECT_WIDTH;

  logic                    DemuxIn;
  logic [SELECT_WIDTH-1:0] DemuxSel;
  logic                    DemuxAuto;
  logic                    DemuxWrEn;
  logic                    DemuxInReady;
  logic [W-1:0]            DemuxOut;
  logic                    DemuxOutValid;
  logic                    DemuxOutReady;

  modport master (
    output DemuxIn, DemuxSel, DemuxAuto, DemuxWrEn, DemuxOutReady,
    input  DemuxInReady, DemuxOut, DemuxOutValid
  );

  modport slave (
    input  DemuxIn, DemuxSel, DemuxAuto, DemuxWrEn, DemuxOutReady,
    output DemuxInReady, DemuxOut, DemuxOutValid
  );

endinterface

// File: rtl/nbit_wrap_counter.sv
// Auto-mode bit position counter; wraps modulo 2^SELECT_WIDTH, clear has priority over increment.
module nbit_wrap_counter #(
  parameter int SELECT_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic [SELECT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + SELECT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/nbit_demux_collect.sv
// Serial-to-parallel bit collector: steers single bits into a registered word, presents it when
// every position has been written at least once, and holds it until the consumer takes it.
module nbit_demux_collect
  import nbit_demux_collect_pkg::*;
#(
  parameter int SELECT_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  nbit_demux_collect_if.slave        bus,
  output state_t                     dbg_state
);

  localparam int W = word_width(SELECT_WIDTH);

  state_t                  state;
  logic [W-1:0]            word;
  logic [W-1:0]            mask;
  logic [W-1:0]            next_mask;
  logic [SELECT_WIDTH-1:0] count;
  logic [SELECT_WIDTH-1:0] pos;
  logic                    accept;
  logic                    release_word;
  logic                    out_valid;
  logic                    in_ready;

  assign accept       = (state == COLLECT) && bus.DemuxWrEn;
  assign release_word = (state == HOLD) && bus.DemuxOutReady;
  assign pos          = bus.DemuxAuto ? count : bus.DemuxSel;
  // Completion looks at the mask including the bit being written this cycle.
  assign next_mask    = mask | (W'(1) << pos);

  nbit_wrap_counter #(.SELECT_WIDTH(SELECT_WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && bus.DemuxAuto),
    .clr   (release_word),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      word      <= '0;
      mask      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            word[pos] <= bus.DemuxIn;
            mask      <= next_mask;
            if (&next_mask) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        HOLD: begin
          // The old word stays on DemuxOut and is overwritten bit by bit in the next round.
          if (bus.DemuxOutReady) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            mask      <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.DemuxOut      = word;
  assign bus.DemuxOutValid = out_valid;
  assign bus.DemuxInReady  = in_ready;
  assign dbg_state         = state;

endmodule

// File: tb/tb_nbit_demux_collect.sv
// Bench for nbit_demux_collect at SELECT_WIDTH=2: directed scenarios then random traffic,
// checked against a bit-array reference model and a word scoreboard.
module tb_nbit_demux_collect;
  import nbit_demux_collect_pkg::*;

  localparam int SW = 2;
  localparam int W  = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg_state;

  nbit_demux_collect_if #(.SELECT_WIDTH(SW)) bus();

  nbit_demux_collect #(.SELECT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  // reference model: per-position data and written flags, plain integer position counter
  bit m_bits[W];
  bit m_seen[W];
  int m_count;
  bit m_hold;

  function automatic logic [W-1:0] m_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = m_bits[i];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_bits[i] = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_count = 0;
    m_hold  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit wren, input bit auto_m, input int sel, input bit din,
                            input bit oready);
    int  pos;
    bit  done;
    if (m_hold) begin
      if (oready) begin
        m_hold  = 1'b0;
        m_count = 0;
        for (int i = 0; i < W; i++) m_seen[i] = 1'b0;
      end
    end else if (wren) begin
      pos = auto_m ? m_count : sel;
      m_bits[pos] = din;
      m_seen[pos] = 1'b1;
      if (auto_m) m_count = (m_count + 1) % W;
      done = 1'b1;
      for (int i = 0; i < W; i++) if (!m_seen[i]) done = 1'b0;
      if (done) begin
        exp_q.push_back(m_word());
        m_hold = 1'b1;
      end
    end
  endtask

  // driver: called at a falling edge, applies one cycle and checks registered outputs
  task automatic cycle(input bit wren, input bit auto_m, input int sel, input bit din,
                       input bit oready);
    bus.DemuxWrEn     = wren;
    bus.DemuxAuto     = auto_m;
    bus.DemuxSel      = sel[SW-1:0];
    bus.DemuxIn       = din;
    bus.DemuxOutReady = oready;
    model_step(wren, auto_m, sel, din, oready);
    @(posedge clk);
    @(negedge clk);
    check("in_ready", bus.DemuxInReady, !m_hold);
    check("out_valid", bus.DemuxOutValid, m_hold);
    check("word", bus.DemuxOut, m_word());
  endtask

  task automatic do_reset();
    bus.DemuxWrEn     = 1'($urandom_range(0, 1));
    bus.DemuxIn       = 1'($urandom_range(0, 1));
    bus.DemuxAuto     = 1'($urandom_range(0, 1));
    bus.DemuxOutReady = 1'($urandom_range(0, 1));
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_word", bus.DemuxOut, 0);
    check("reset_valid", bus.DemuxOutValid, 0);
    check("reset_in_ready", bus.DemuxInReady, 1);
    check("reset_state", dbg_state, COLLECT);
  endtask

  // monitor: pops the scoreboard each time a new word is presented
  initial begin
    logic [W-1:0] e;
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.DemuxOutValid === 1'b1 && !prev_valid && !rst) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_word: got %0h expected no word at %0t", bus.DemuxOut, $time);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_word", bus.DemuxOut, e);
        end
      end
      prev_valid = (bus.DemuxOutValid === 1'b1);
    end
  end

  initial begin
    bus.DemuxWrEn     = 1'b1;
    bus.DemuxAuto     = 1'b1;
    bus.DemuxSel      = '0;
    bus.DemuxIn       = 1'b1;
    bus.DemuxOutReady = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // auto fill 1,0,1,1
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    check("fill_word", bus.DemuxOut, 4'b1101);
    check("fill_valid", bus.DemuxOutValid, 1);
    check("fill_in_ready", bus.DemuxInReady, 0);

    // back-pressure: writes are ignored while held
    repeat (5) cycle(1, 1, int'($urandom_range(0, 3)), 0, 0);
    check("bp_word", bus.DemuxOut, 4'b1101);
    check("bp_valid", bus.DemuxOutValid, 1);
    cycle(0, 0, 0, 0, 1);
    check("release_valid", bus.DemuxOutValid, 0);
    check("release_in_ready", bus.DemuxInReady, 1);
    check("release_state", dbg_state, COLLECT);

    // addressed with overwrite
    cycle(1, 0, 3, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 3, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check("addr_not_done", bus.DemuxOutValid, 0);
    cycle(1, 0, 2, 1, 0);
    check("addr_word", bus.DemuxOut, 4'b0101);
    check("addr_valid", bus.DemuxOutValid, 1);
    cycle(0, 0, 0, 0, 1);

    // mixed mode: auto pos 0,1, addressed pos 3, auto pos 2
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 3, 0, 0);
    cycle(1, 1, 0, 1, 0);
    check("mixed_word", bus.DemuxOut, 4'b0111);
    check("mixed_valid", bus.DemuxOutValid, 1);
    cycle(0, 0, 0, 0, 1);

    // reset mid-word
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    check("rst_mid_word", bus.DemuxOut, 4'b1000);
    check("rst_mid_valid", bus.DemuxOutValid, 1);
    cycle(0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
